exu_cal: RTL and testbench



---
 rtl/exu_cal.sv | 60 ++++++
 tb/tb_exu_cal.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/exu_cal.sv
// exu_cal: shared ALU calculation centre; 1-cycle add/sub/xor/cmp, iterative 1-bit-per-cycle shifts
module exu_cal #(
    parameter int CAL_OPB_SIZE = 73,
    parameter int XLEN         = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    hs_al4cal_val,
    output logic                    hs_cal4al_rdy,
    input  logic [CAL_OPB_SIZE-1:0] i_cal_opb,
    output logic [XLEN-1:0]         o_cal_res
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_nxt;
    logic [6:0]      op;
    logic [32:0]     opn1, opn2;
    logic [4:0]      shamt, cnt;
    logic [XLEN-1:0] shreg, alu_res;
    logic            is_sh, lt, shl, fill;
    assign op    = i_cal_opb[6:0];
    assign opn1  = i_cal_opb[39:7];
    assign opn2  = i_cal_opb[72:40];
    assign shamt = opn2[4:0];
    // ADD and SUB outrank the shifts; XOR/CMP only matter when no shift bit is set
    assign is_sh = ~op[0] & ~op[1] & |op[4:2];
    // signed 33-bit compare == sign of the 34-bit difference; serves SLT and SLTU
    assign lt    = $signed(opn1) < $signed(opn2);
    assign alu_res = op[0] ? opn1[31:0] + opn2[31:0] :
                     op[1] ? opn1[31:0] - opn2[31:0] :
                     op[5] ? opn1[31:0] ^ opn2[31:0] :
                     op[6] ? {{(XLEN-1){1'b0}}, lt} : '0;
    always_comb begin
        state_nxt = state == IDLE  ? (hs_al4cal_val ? ((is_sh && shamt != 5'd0) ? SHIFT : DONE) : IDLE) :
                    state == SHIFT ? (!hs_al4cal_val ? IDLE : (cnt == 5'd1) ? DONE : SHIFT) :
                    IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
            shl   <= 1'b0;
            fill  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && hs_al4cal_val) begin
                shreg <= is_sh ? opn1[31:0] : alu_res;
                cnt   <= shamt;
                shl   <= op[2];
                fill  <= ~op[2] & ~op[3] & opn1[31];
            end else if (state == SHIFT) begin
                shreg <= shl ? {shreg[XLEN-2:0], 1'b0} : {fill, shreg[XLEN-1:1]};
                cnt   <= cnt - 5'd1;
            end
        end
    end
    // dropping val in DONE flushes the result without a handshake
    assign hs_cal4al_rdy = (state == DONE) & hs_al4cal_val;
    assign o_cal_res     = hs_cal4al_rdy ? shreg : '0;
endmodule

// File: tb/tb_exu_cal.sv
// tb_exu_cal: scoreboard bench for exu_cal; expected result and latency queued at issue, checked at rdy
module tb_exu_cal;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        val = 1'b0;
    logic        rdy;
    logic [72:0] opb = '0;
    logic [31:0] res;
    int          nchk = 0;
    int          nfail = 0;
    logic [31:0] exp_q[$];
    int          lat_q[$];
    localparam logic [6:0] ADD = 7'd1, SUB = 7'd2, SLL = 7'd4, SRL = 7'd8, SRA = 7'd16, XOR = 7'd32, CMP = 7'd64;
    exu_cal dut (
        .clk(clk), .rst_n(rst_n), .hs_al4cal_val(val), .hs_cal4al_rdy(rdy),
        .i_cal_opb(opb), .o_cal_res(res)
    );
    always #5 clk = ~clk;
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    task automatic do_req(input string name, input logic [6:0] op, input logic [32:0] a, input logic [32:0] b,
                          input logic [31:0] er, input int el, input bit chain);
        int lat;
        logic [31:0] got, er2;
        int el2;
        exp_q.push_back(er);
        lat_q.push_back(el);
        val = 1'b1;
        opb = {b, a, op};
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!rdy && lat < 64);
        er2 = exp_q.pop_front();
        el2 = lat_q.pop_front();
        got = res;
        nchk++;
        if (rdy !== 1'b1) begin
            nfail++;
            $display("FAIL %s timeout: rdy=%b after %0d cycles, required rdy=1 at %0d", name, rdy, lat, el2);
        end else begin
            if (got !== er2) begin
                nfail++;
                $display("FAIL %s result: got %h required %h", name, got, er2);
            end
            nchk++;
            if (lat != el2) begin
                nfail++;
                $display("FAIL %s latency: got %0d required %0d", name, lat, el2);
            end
        end
        @(posedge clk); #1;
        nchk++;
        if (rdy !== 1'b0 || res !== 32'h0) begin
            nfail++;
            $display("FAIL %s after-pulse: rdy=%b res=%h required rdy=0 res=0", name, rdy, res);
        end
        if (!chain) val = 1'b0;
    endtask
    task automatic test_reset;
        rst_n = 1'b0;
        val = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        nchk++;
        if (rdy !== 1'b0 || res !== 32'h0) begin
            nfail++;
            $display("FAIL reset: rdy=%b res=%h required rdy=0 res=0", rdy, res);
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            nchk++;
            if (rdy !== 1'b0) begin
                nfail++;
                $display("FAIL idle_no_val: rdy=%b required 0", rdy);
            end
        end
    endtask
    task automatic test_arith;
        do_req("add_ovf", ADD, 33'h0_7FFFFFFF, 33'h1, 32'h80000000, 1, 0);
        do_req("sub", SUB, 33'h5, 33'h7, 32'hFFFFFFFE, 1, 0);
        do_req("xor", XOR, 33'h0_12345678, 33'h0_FFFF0000, 32'hEDCB5678, 1, 0);
    endtask
    task automatic test_cmp;
        do_req("cmp_signed", CMP, 33'h1_FFFFFFFF, 33'h1, 32'h1, 1, 0);
        do_req("cmp_unsigned", CMP, 33'h0_FFFFFFFF, 33'h1, 32'h0, 1, 0);
        do_req("cmp_equal", CMP, 33'h5, 33'h5, 32'h0, 1, 0);
    endtask
    task automatic test_shift;
        do_req("sra4", SRA, 33'h1_80000010, 33'h4, 32'hF8000001, 5, 0);
        do_req("srl4", SRL, 33'h1_80000010, 33'h4, 32'h08000001, 5, 0);
        do_req("sll0", SLL, 33'h1_80000010, 33'h0, 32'h80000010, 1, 0);
        do_req("sll31", SLL, 33'h1, 33'h1F, 32'h80000000, 32, 0);
        do_req("sll_amt_hi_ignored", SLL, 33'h1, 33'h20, 32'h1, 1, 0);
        do_req("srl31", SRL, 33'h0_80000000, 33'h1_FFFFFFFF, 32'h1, 32, 0);
    endtask
    task automatic test_illegal;
        do_req("none", 7'd0, 33'h5, 33'h3, 32'h0, 1, 0);
        do_req("add_over_sub", ADD | SUB, 33'h5, 33'h3, 32'h8, 1, 0);
        do_req("sub_over_sll", SUB | SLL, 33'h5, 33'h7, 32'hFFFFFFFE, 1, 0);
        do_req("sll_over_sra", SLL | SRA, 33'h1, 33'h4, 32'h10, 5, 0);
        do_req("srl_over_sra", SRL | SRA, 33'h1_80000000, 33'h1, 32'h40000000, 2, 0);
        do_req("xor_over_cmp", XOR | CMP, 33'h6, 33'h3, 32'h5, 1, 0);
    endtask
    task automatic test_back_to_back;
        do_req("b2b_add", ADD, 33'h10, 33'h20, 32'h30, 1, 1);
        do_req("b2b_sra", SRA, 33'h1_F0000000, 33'h2, 32'hFC000000, 3, 1);
        do_req("b2b_sub", SUB, 33'h0, 33'h1, 32'hFFFFFFFF, 1, 0);
    endtask
    task automatic test_abort;
        val = 1'b1;
        opb = {33'd10, 33'd1, SLL};
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk); #1;
            if (i == 4) val = 1'b0;
            nchk++;
            if (rdy !== 1'b0 || res !== 32'h0) begin
                nfail++;
                $display("FAIL abort cycle %0d: rdy=%b res=%h required rdy=0 res=0", i, rdy, res);
            end
        end
        @(posedge clk); #1;
        do_req("after_abort_add", ADD, 33'h2, 33'h3, 32'h5, 1, 0);
    endtask
    task automatic test_reset_mid;
        val = 1'b1;
        opb = {33'd20, 33'h3, SLL};
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        nchk++;
        if (rdy !== 1'b0 || res !== 32'h0) begin
            nfail++;
            $display("FAIL reset_mid: rdy=%b res=%h required rdy=0 res=0", rdy, res);
        end
        val = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_req("xor_after_reset", XOR, 33'h0_FFFF0000, 33'h0_0F0F0F0F, 32'hF0F00F0F, 1, 0);
    endtask
    initial begin
        test_reset;
        test_arith;
        test_cmp;
        test_shift;
        test_illegal;
        test_back_to_back;
        test_abort;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
